// File: rtl/imem_loader_if.sv
// Signal bundle between the instruction-memory loader and its surroundings:
// framed byte stream in, memory write/read port out, session status out.
interface imem_loader_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              load_req;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              cpu_hold;
   logic              done;
   logic              err;
   logic [1:0]        err_code;

   modport master (
      input  load_req, in_valid, in_data, mem_rdata,
      output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err, err_code
   );

   modport slave (
      output load_req, in_valid, in_data, mem_rdata,
      input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err, err_code
   );
endinterface

// File: rtl/imem_loader.sv
// Loads a LEN/data/CSUM framed byte stream into instruction memory, read-verifying
// every byte after it is written, and holds the CPU for the whole session.
module imem_loader #(
   parameter int                ADDR_W    = 8,
   parameter int                DATA_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic          clk,
   input  logic          reset,
   imem_loader_if.master bus
);
   localparam int               CNT_W    = ADDR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_DATA, S_WRITE, S_VERIFY, S_CSUM, S_DONE
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'b00,
      ERR_CSUM   = 2'b01,
      ERR_VERIFY = 2'b10
   } err_code_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic [DATA_W-1:0] byte_q, byte_d;
   logic              err_q, err_d;
   err_code_e         err_code_q, err_code_d;
   logic              in_ready_q, in_ready_d;
   logic              mem_we_q, mem_we_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              done_q, done_d;

   logic              xfer;
   logic [DATA_W-1:0] csum_total;
   logic [CNT_W-1:0]  len_cnt;

   assign xfer       = bus.in_valid & in_ready_q;
   assign csum_total = sum_q + bus.in_data;
   // A LEN byte of zero means a full memory image.
   assign len_cnt    = (bus.in_data == '0) ? FULL_CNT : CNT_W'(bus.in_data);

   always_comb begin
      // NOTE: every _d gets a default first so no branch can leave one unassigned and infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      sum_d      = sum_q;
      byte_d     = byte_q;
      err_d      = err_q;
      err_code_d = err_code_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.load_req) begin
               state_d    = S_LEN;
               err_d      = 1'b0;
               err_code_d = ERR_NONE;
            end
         end
         S_LEN: begin
            if (xfer) begin
               cnt_d   = len_cnt;
               addr_d  = BASE_ADDR;
               sum_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (xfer) begin
               byte_d  = bus.in_data;
               sum_d   = sum_q + bus.in_data;
               state_d = S_WRITE;
            end
         end
         S_WRITE: state_d = S_VERIFY;
         S_VERIFY: begin
            if (bus.mem_rdata != byte_q) begin
               err_d      = 1'b1;
               err_code_d = ERR_VERIFY;
               state_d    = S_DONE;
            end else begin
               addr_d  = addr_q + 1'b1;
               cnt_d   = cnt_q - 1'b1;
               state_d = (cnt_q == LAST_CNT) ? S_CSUM : S_DATA;
            end
         end
         S_CSUM: begin
            if (xfer) begin
               if (csum_total != '0) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_CSUM;
               end
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they register alongside it.
      in_ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
      mem_we_d   = (state_d == S_WRITE);
      cpu_hold_d = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         sum_q      <= '0;
         byte_q     <= '0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
         in_ready_q <= 1'b0;
         mem_we_q   <= 1'b0;
         cpu_hold_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         sum_q      <= sum_d;
         byte_q     <= byte_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         in_ready_q <= in_ready_d;
         mem_we_q   <= mem_we_d;
         cpu_hold_q <= cpu_hold_d;
         done_q     <= done_d;
      end
   end

   // Address and write data come straight from the working registers.
   assign bus.in_ready  = in_ready_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = byte_q;
   assign bus.cpu_hold  = cpu_hold_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.err_code  = err_code_q;
endmodule
